// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes
// and the frame-length helper used by TX and RX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_len(
        input int clk_div,
        input int data_bits,
        input int parity,
        input int stop_bits
    );
        int par_bits;
        par_bits = (parity != PAR_NONE) ? 1 : 0;
        return clk_div * (1 + data_bits + par_bits + stop_bits);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO queueing transmit words.
// Pointers carry one extra MSB to tell full from empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                     (r_wptr[AW] != r_rptr[AW]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Advance write/read pointers on accepted push/pop.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)
                r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable framing and a
// write-side FIFO; frames are sent back-to-back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 txd
);

    localparam int BW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_MAX  = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_MAX = CW'(STOP_BITS - 1);

    uart_state_t          r_state;
    logic [BW-1:0]        r_baud;
    logic [CW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_txd;
    logic                 r_ovf;

    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic                 w_baud_end;
    logic                 w_last;
    logic                 w_pop;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_push  (wr_en),
        .i_pop   (w_pop),
        .i_wdata (wr_data),
        .o_rdata (w_head),
        .o_full  (full),
        .o_empty (empty)
    );

    assign w_baud_end = (r_baud == BAUD_MAX);
    assign w_last     = (r_state == STOP) && w_baud_end &&
                        (r_bit == STOP_MAX);
    assign w_pop      = ~empty & ((r_state == IDLE) | w_last);
    assign w_head_par = (PARITY == PAR_ODD) ? ~(^w_head) : (^w_head);

    assign txd      = r_txd;
    assign overflow = r_ovf;
    assign busy     = (r_state != IDLE);
    assign tx_done  = w_last;

    // Frame sequencer: baud/bit counting, shifting and the line register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            if (r_state == IDLE)
                r_baud <= '0;
            else if (w_baud_end)
                r_baud <= '0;
            else
                r_baud <= r_baud + BW'(1);

            unique case (r_state)
                IDLE: begin
                end
                START: begin
                    if (w_baud_end) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == BIT_MAX) begin
                            r_bit <= '0;
                            if (PARITY != PAR_NONE) begin
                                r_state <= PAR;
                                r_txd   <= r_par;
                            end else begin
                                r_state <= STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + CW'(1);
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                PAR: begin
                    if (w_baud_end) begin
                        r_state <= STOP;
                        r_bit   <= '0;
                        r_txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        if (r_bit == STOP_MAX)
                            r_state <= IDLE;
                        else
                            r_bit <= r_bit + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_pop) begin
                r_state <= START;
                r_txd   <= 1'b0;
                r_shift <= w_head;
                r_par   <= w_head_par;
            end
        end
    end

    // Flag a write that arrives while the FIFO is full.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr)
            r_ovf <= 1'b0;
        else
            r_ovf <= wr_en & full;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover
// 8N1, 8E1, 8O1 and 5N2 framing at CLK_DIV=4.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CD = 4;

    logic       clk;
    logic       clr;
    logic [3:0] wr_en_v;
    logic [7:0] wd_a;
    logic [7:0] wd_b;
    logic [7:0] wd_c;
    logic [4:0] wd_d;
    logic [3:0] full_v;
    logic [3:0] empty_v;
    logic [3:0] ovf_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] txd_v;

    int n_assert;
    int n_fail;

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .clr(clr), .wr_en(wr_en_v[0]), .wr_data(wd_a),
        .full(full_v[0]), .empty(empty_v[0]), .overflow(ovf_v[0]),
        .busy(busy_v[0]), .tx_done(done_v[0]), .txd(txd_v[0]));

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .clr(clr), .wr_en(wr_en_v[1]), .wr_data(wd_b),
        .full(full_v[1]), .empty(empty_v[1]), .overflow(ovf_v[1]),
        .busy(busy_v[1]), .tx_done(done_v[1]), .txd(txd_v[1]));

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .clr(clr), .wr_en(wr_en_v[2]), .wr_data(wd_c),
        .full(full_v[2]), .empty(empty_v[2]), .overflow(ovf_v[2]),
        .busy(busy_v[2]), .tx_done(done_v[2]), .txd(txd_v[2]));

    uart_tx_fifo #(.CLK_DIV(CD), .DATA_BITS(5), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .clr(clr), .wr_en(wr_en_v[3]), .wr_data(wd_d),
        .full(full_v[3]), .empty(empty_v[3]), .overflow(ovf_v[3]),
        .busy(busy_v[3]), .tx_done(done_v[3]), .txd(txd_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int s, input logic en, input logic [7:0] d);
        wr_en_v[s] = en;
        case (s)
            0: wd_a = d;
            1: wd_b = d;
            2: wd_c = d;
            default: wd_d = d[4:0];
        endcase
    endtask

    // Expected line levels, index 0 = start bit.
    function automatic logic [15:0] mk_frame(input logic [7:0] d,
                                             input int nb, input int par);
        logic [15:0] f;
        logic        x;
        f = '1;
        x = 1'b0;
        f[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[1+i] = d[i];
            x = x ^ d[i];
        end
        if (par != PAR_NONE)
            f[1+nb] = (par == PAR_ODD) ? ~x : x;
        return f;
    endfunction

    // Check frame cycles k0..k1-1 on instance s, one cycle per step.
    task automatic run_frame(input int s, input logic [15:0] fr,
                             input int len, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            chk($sformatf("txd s%0d k%0d", s, k), 32'(txd_v[s]),
                32'(fr[k/CD]));
            chk($sformatf("done s%0d k%0d", s, k), 32'(done_v[s]),
                32'(k == len - 1));
            chk($sformatf("busy s%0d k%0d", s, k), 32'(busy_v[s]), 32'd1);
            tick();
        end
    endtask

    initial begin
        int L8n1;
        int L8p;
        int L5n2;
        n_assert = 0;
        n_fail   = 0;
        clr      = 1'b0;
        wr_en_v  = '0;
        wd_a = '0; wd_b = '0; wd_c = '0; wd_d = '0;
        L8n1 = frame_len(CD, 8, PAR_NONE, 1);
        L8p  = frame_len(CD, 8, PAR_EVEN, 1);
        L5n2 = frame_len(CD, 5, PAR_NONE, 2);
        chk("len 8n1", 32'(L8n1), 32'd40);
        chk("len 8e1", 32'(L8p), 32'd44);
        chk("len 5n2", 32'(L5n2), 32'd32);

        tick();
        tick();
        chk("rst txd", 32'(txd_v), 32'hF);
        chk("rst busy", 32'(busy_v), 32'h0);
        chk("rst done", 32'(done_v), 32'h0);
        chk("rst ovf", 32'(ovf_v), 32'h0);
        chk("rst empty", 32'(empty_v), 32'hF);
        chk("rst full", 32'(full_v), 32'h0);
        clr = 1'b1;
        tick();

        // 8N1 single byte 0x55
        wr(0, 1'b1, 8'h55);
        tick();
        wr(0, 1'b0, 8'h00);
        chk("lat empty0", 32'(empty_v[0]), 32'd0);
        chk("lat txd1", 32'(txd_v[0]), 32'd1);
        tick();
        chk("lat empty1", 32'(empty_v[0]), 32'd1);
        run_frame(0, 16'h02AA, L8n1, 0, L8n1);
        chk("8n1 idle busy", 32'(busy_v[0]), 32'd0);
        chk("8n1 idle txd", 32'(txd_v[0]), 32'd1);

        // even and odd parity on 0x07
        wr(1, 1'b1, 8'h07);
        wr(2, 1'b1, 8'h07);
        tick();
        wr(1, 1'b0, 8'h00);
        wr(2, 1'b0, 8'h00);
        tick();
        fork
            run_frame(1, 16'h060E, L8p, 0, L8p);
            run_frame(2, 16'h040E, L8p, 0, L8p);
        join
        chk("par idle busy", 32'(busy_v[2:1]), 32'd0);

        // 5 data bits, 2 stop bits
        wr(3, 1'b1, 8'h1F);
        tick();
        wr(3, 1'b0, 8'h00);
        tick();
        run_frame(3, 16'h00FE, L5n2, 0, L5n2);
        chk("5n2 idle busy", 32'(busy_v[3]), 32'd0);
        chk("5n2 idle txd", 32'(txd_v[3]), 32'd1);

        // FIFO fill, overflow and back-to-back frames
        wr(0, 1'b1, 8'hA1);
        tick();
        wr(0, 1'b1, 8'hA2);
        tick();
        chk("fill txd0", 32'(txd_v[0]), 32'd0);
        wr(0, 1'b1, 8'hA3);
        tick();
        wr(0, 1'b1, 8'hA4);
        tick();
        wr(0, 1'b1, 8'hA5);
        tick();
        chk("fill full", 32'(full_v[0]), 32'd1);
        chk("fill ovf0", 32'(ovf_v[0]), 32'd0);
        wr(0, 1'b1, 8'hA6);
        tick();
        wr(0, 1'b0, 8'h00);
        chk("ovf pulse", 32'(ovf_v[0]), 32'd1);
        chk("ovf full", 32'(full_v[0]), 32'd1);
        tick();
        chk("ovf clear", 32'(ovf_v[0]), 32'd0);
        run_frame(0, mk_frame(8'hA1, 8, 0), L8n1, 5, L8n1);
        run_frame(0, mk_frame(8'hA2, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hA3, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hA4, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hA5, 8, 0), L8n1, 0, L8n1);
        chk("fill end busy", 32'(busy_v[0]), 32'd0);
        chk("fill end empty", 32'(empty_v[0]), 32'd1);

        // push while full in the same cycle as a pop
        wr(0, 1'b1, 8'hB1);
        tick();
        wr(0, 1'b1, 8'hB2);
        tick();
        wr(0, 1'b1, 8'hB3);
        tick();
        wr(0, 1'b1, 8'hB4);
        tick();
        wr(0, 1'b1, 8'hB5);
        tick();
        wr(0, 1'b0, 8'h00);
        chk("pp full", 32'(full_v[0]), 32'd1);
        run_frame(0, mk_frame(8'hB1, 8, 0), L8n1, 3, L8n1 - 1);
        chk("pp done", 32'(done_v[0]), 32'd1);
        chk("pp full2", 32'(full_v[0]), 32'd1);
        wr(0, 1'b1, 8'hB6);
        tick();
        wr(0, 1'b0, 8'h00);
        chk("pp ovf", 32'(ovf_v[0]), 32'd1);
        chk("pp not full", 32'(full_v[0]), 32'd0);
        run_frame(0, mk_frame(8'hB2, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hB3, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hB4, 8, 0), L8n1, 0, L8n1);
        run_frame(0, mk_frame(8'hB5, 8, 0), L8n1, 0, L8n1);
        chk("pp end busy", 32'(busy_v[0]), 32'd0);
        chk("pp end empty", 32'(empty_v[0]), 32'd1);

        // reset during the third data bit with two entries queued
        wr(0, 1'b1, 8'hC3);
        tick();
        wr(0, 1'b1, 8'h5A);
        tick();
        wr(0, 1'b1, 8'h5B);
        tick();
        wr(0, 1'b0, 8'h00);
        run_frame(0, mk_frame(8'hC3, 8, 0), L8n1, 1, 13);
        chk("mid txd", 32'(txd_v[0]), 32'd0);
        chk("mid empty", 32'(empty_v[0]), 32'd0);
        #1 clr = 1'b0;
        #1;
        chk("arst txd", 32'(txd_v[0]), 32'd1);
        chk("arst busy", 32'(busy_v[0]), 32'd0);
        chk("arst empty", 32'(empty_v[0]), 32'd1);
        chk("arst done", 32'(done_v[0]), 32'd0);
        tick();
        tick();
        clr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk($sformatf("post txd %0d", i), 32'(txd_v[0]), 32'd1);
            chk($sformatf("post done %0d", i), 32'(done_v[0]), 32'd0);
            chk($sformatf("post busy %0d", i), 32'(busy_v[0]), 32'd0);
        end
        chk("post empty", 32'(empty_v[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO. It generalises the fixed 8N1 transmitter with the following configurable features:
- data width, parity, stop-bit count and baud divisor;
- a write-side FIFO so software can queue several bytes;
- back-to-back framing with no idle gap.

It sits between the bus/register interface and the serial pin. It pairs with the UART receiver in the same UART subsystem.

## Interface
- CLK_DIV, 16: clk cycles per serial bit; legal range ≥2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous reset, active-low.
- wr_en  in  1  write strobe; pushes wr_data when sampled high.
- wr_data  in  DATA_BITS  byte to queue.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds zero entries.
- overflow  out  1  one-cycle pulse when a write is dropped.
- busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse at the end of each frame.
- txd  out  1  serial output; idles high.

## Operation
- **Reset (clr low):**
  - txd=1, busy=0, tx_done=0, overflow=0, empty=1, full=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - Asserting clr mid-frame aborts the frame immediately (asynchronously) and discards queued data.
- **FIFO writes:**
  - wr_en with full=0 pushes wr_data.
  - wr_en with full=1 drops the data and pulses overflow the next cycle. This applies even if a pop occurs in the same cycle.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START when empty=0: the head entry is popped into the shift register and txd is driven 0.
  - START → DATA after CLK_DIV cycles.
  - DATA sends the bits LSB first, each held CLK_DIV cycles. After DATA_BITS bits it goes to PAR if PARITY≠0, else to STOP.
  - PAR → STOP after CLK_DIV cycles.
  - STOP holds txd=1 for STOP_BITS×CLK_DIV cycles. On its final cycle it pulses tx_done and goes to START if the FIFO is non-empty (popping the next entry), else to IDLE.
- **Parity bit:**
  - Even mode: XOR of the data bits.
  - Odd mode: the inverse of that XOR.
  - The XOR is computed on the data latched at pop, not the live wr_data.
- **Counters:**
  - Baud counter is $clog2(CLK_DIV) bits wide and counts 0..CLK_DIV-1, wrapping at the bit boundary.
  - Bit counter is $clog2(DATA_BITS+1) bits wide.
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with the MSB used for full/empty disambiguation.
- **Busy:** high from entry to START until the final STOP cycle. It stays high across back-to-back frames.
- **Output register:** txd is a registered output and is glitch-free.

## Timing
- **Write-to-line latency:** wr_data written at edge E into an idle, empty block appears as txd falling at edge E+1. empty rises again at E+1 if this was the only entry.
- **Frame length:** exactly CLK_DIV×(1+DATA_BITS+(PARITY?1:0)+STOP_BITS) cycles.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle, with zero idle cycles.
- **Flag timing:** full and empty update the cycle after the push or pop edge. A push and a pop in the same cycle leave the count unchanged.
- **tx_done:** high for exactly one cycle, coincident with the final stop-bit cycle.
- **Configuration:** all parameters are static; there is no runtime reconfiguration.

## Structure
- **Shared package uart_pkg:**
  - FSM state enum (IDLE, START, DATA, PAR, STOP).
  - Parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2.
  - The frame-length function.
  - The same package is used by the receiver.
- **Sub-module uart_fifo** (parameters WIDTH, DEPTH): synchronous single-clock FIFO with push/pop/full/empty. The top level holds the FSM, the baud and bit counters, the shift register and the parity logic.
- **Expected size:** 150–250 lines of RTL in total.

## Test plan
All scenarios use CLK_DIV=4 unless stated otherwise.
- **8N1, single byte.** Write 0x55 while idle → txd falls one edge later. The sequence is 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. tx_done pulses at cycle 40 of the frame; busy=0 afterward.
- **Even parity.** Write 0x07 → parity bit = 1; frame is 44 cycles. With odd parity the same byte gives parity bit = 0.
- **FIFO fill and overflow.** FIFO_DEPTH=4: 5 consecutive writes (0xA1..0xA5) while idle → the first is popped immediately and the 5th is accepted.
  - A 6th write gives full=1 and one overflow pulse; 0xA6 is dropped.
  - Five frames go out back-to-back with no gap; tx_done pulses 5 times, 40 cycles apart.
- **DATA_BITS=5, STOP_BITS=2.** Write 0x1F → frame is 0,1,1,1,1,1,1,1 (32 cycles). Only bits [4:0] are sent.
- **Reset mid-frame.** Assert clr during the third data bit with 2 entries queued → txd=1 and busy=0 immediately; after clr, empty=1. No tx_done pulse; no frame starts until a new write.
- **Simultaneous push and pop.** With full=1 and the FSM popping, wr_en in the same cycle → overflow pulses and the occupancy becomes DEPTH-1.
